// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: opcodes, FSM encodings and
// instruction field placement.
package alu_pkg;

  // Arithmetic opcodes (L=0)
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEGA = 2'b10;
  localparam logic [1:0] OP_NEGB = 2'b11;

  // Logic opcodes (L=1)
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Register fields are placed in units of AW bits from the LSB;
  // Op sits directly above rd and L is the MSB.
  localparam int F_RB = 0;
  localparam int F_RA = 1;
  localparam int F_RD = 2;
  localparam int F_OP = 3;

  function automatic int instr_width(input int aw);
    return 3 + 3 * aw;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake between an instruction source and alu_issue.
// A transfer happens on a rising clock edge where in_valid and in_ready are both 1;
// the source holds in_valid and in_instr stable until that edge.
interface alu_issue_if #(
  parameter int AW = 2
) ();
  import alu_pkg::*;

  localparam int IW = instr_width(AW);

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);

endinterface

// File: rtl/alu_issue_alu.sv
// Combinational DW-bit ALU. Carry is bit DW of a DW+1-bit sum; in logic
// mode the carry and sign outputs are don't-care.
module alu #(
  parameter int DW = 4
) (
  output logic [DW-1:0] R,
  output logic          z,
  output logic          c,
  output logic          s,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [1:0]    Op,
  input  logic          L
);
  import alu_pkg::*;

  logic [DW:0] sum;

  always_comb begin
    sum = '0;
    if (!L) begin
      unique case (Op)
        OP_ADD:  sum = {1'b0, A} + {1'b0, B};
        OP_SUB:  sum = {1'b0, A} + {1'b0, ~B} + {{DW{1'b0}}, 1'b1};
        OP_NEGA: sum = {1'b0, ~A} + {{DW{1'b0}}, 1'b1};
        OP_NEGB: sum = {1'b0, ~B} + {{DW{1'b0}}, 1'b1};
        default: sum = '0;
      endcase
    end else begin
      unique case (Op)
        OP_AND:  sum = {1'b0, A & B};
        OP_OR:   sum = {1'b0, A | B};
        OP_XOR:  sum = {1'b0, A ^ B};
        OP_NOTA: sum = {1'b0, ~A};
        default: sum = '0;
      endcase
    end
  end

  assign R = sum[DW-1:0];
  assign z = (sum[DW-1:0] == '0);
  assign c = sum[DW];
  assign s = sum[DW-1];

endmodule

// File: rtl/alu_issue.sv
// Sequential issue unit around the combinational ALU: fetches operands from
// an internal register bank, executes, and writes back result and flags.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  alu_issue_if.slave    iss,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] res,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_s,
  output logic          done,
  output state_t        dbg_state
);

  localparam int NREG = 2 ** AW;
  localparam int IW   = instr_width(AW);

  state_t        state;
  logic [IW-1:0] instr_q;
  logic [DW-1:0] bank [NREG];
  logic [DW-1:0] a_q, b_q, r_q;
  logic          z_q, c_q, s_q;

  logic [DW-1:0] alu_r;
  logic          alu_z, alu_c, alu_s;

  logic [AW-1:0] rd, ra, rb;
  logic [1:0]    op;
  logic          lmode;

  assign rb    = instr_q[F_RB*AW +: AW];
  assign ra    = instr_q[F_RA*AW +: AW];
  assign rd    = instr_q[F_RD*AW +: AW];
  assign op    = instr_q[F_OP*AW +: 2];
  assign lmode = instr_q[IW-1];

  alu #(.DW(DW)) u_alu (
    .R  (alu_r),
    .z  (alu_z),
    .c  (alu_c),
    .s  (alu_s),
    .A  (a_q),
    .B  (b_q),
    .Op (op),
    .L  (lmode)
  );

  assign iss.in_ready = (state == S_IDLE);
  assign dbg_data     = bank[dbg_addr];
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      res     <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_s  <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else begin
      done <= 1'b0;
      // The write-back below comes later in the block, so it overrides a
      // load to the same register on the same edge.
      if (ld_en) bank[ld_addr] <= ld_data;
      unique case (state)
        S_IDLE: begin
          if (iss.in_valid) begin
            instr_q <= iss.in_instr;
            state   <= S_READ;
          end
        end
        S_READ: begin
          a_q   <= bank[ra];
          b_q   <= bank[rb];
          state <= S_EXEC;
        end
        S_EXEC: begin
          r_q   <= alu_r;
          z_q   <= alu_z;
          c_q   <= alu_c;
          s_q   <= alu_s;
          done  <= 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          bank[rd] <= r_q;
          res      <= r_q;
          flag_z   <= z_q;
          // Logic ops leave carry/sign from the last arithmetic op intact.
          if (!lmode) begin
            flag_c <= c_q;
            flag_s <= s_q;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
